// File: rtl/core_mem_loader_if.sv
// core_mem_loader_if: bundles the core memory port (memwe/memaddr/memdin/memdout)
// and the byte-stream loader handshake (ld_valid/ld_byte/ld_ready).
// master = the side that drives addresses, write data and loader bytes.
// slave  = the memory/loader responder (core_mem_loader).
interface core_mem_loader_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              memwe;
  logic [ADDR_W-1:0] memaddr;
  logic [DATA_W-1:0] memdin;
  logic [DATA_W-1:0] memdout;
  logic              ld_valid;
  logic [7:0]        ld_byte;
  logic              ld_ready;

  modport master (
    output memwe, memaddr, memdin, ld_valid, ld_byte,
    input  memdout, ld_ready
  );

  modport slave (
    input  memwe, memaddr, memdin, ld_valid, ld_byte,
    output memdout, ld_ready
  );
endinterface

// File: rtl/core_mem_loader.sv
// core_mem_loader: unified 32-bit instruction/data RAM with a 1-cycle
// synchronous read port, plus a byte-stream program loader that holds the
// core in reset (core_rstn low) until the image is written.
// Stream format: one count byte (words to load, 0 = 256), then 4 bytes per
// word, least significant byte first.
// Optional build macro MEM_RELOAD_EN: keeps the loader open after the load so
// a new count byte re-enters loading and re-asserts core reset (hot reload).
module core_mem_loader #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rstn,
  core_mem_loader_if.slave    bus,
  output logic                core_rstn,
  output logic                loaded
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    S_LEN  = 2'd0,
    S_DATA = 2'd1,
    S_RUN  = 2'd2
  } state_e;

  // State and loader datapath
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [1:0]        bidx_q, bidx_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [23:0]       shift_q, shift_d;

  // Registered outputs
  logic [DATA_W-1:0] memdout_q;
  logic              ld_ready_q, ld_ready_d;
  logic              core_rstn_q, core_rstn_d;
  logic              loaded_q, loaded_d;

  // RAM write port, shared by loader and core (never active together)
  logic              mem_we_s;
  logic [ADDR_W-1:0] mem_waddr_s;
  logic [DATA_W-1:0] mem_wdata_s;
  logic              xfer_s;

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Next-state, loader datapath and RAM write-port selection
  always_comb begin
    state_d     = state_q;
    wptr_d      = wptr_q;
    bidx_d      = bidx_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    loaded_d    = 1'b0;
    mem_we_s    = 1'b0;
    mem_waddr_s = wptr_q;
    mem_wdata_s = {bus.ld_byte, shift_q};
    xfer_s      = bus.ld_valid && ld_ready_q;

    case (state_q)
      S_LEN: begin
        if (xfer_s) begin
          cnt_d   = bus.ld_byte;
          wptr_d  = {ADDR_W{1'b0}};
          bidx_d  = 2'd0;
          state_d = S_DATA;
        end else begin
          state_d = S_LEN;
        end
      end

      S_DATA: begin
        if (xfer_s) begin
          bidx_d = bidx_q + 2'd1;
          case (bidx_q)
            2'd0:    shift_d[7:0]   = bus.ld_byte;
            2'd1:    shift_d[15:8]  = bus.ld_byte;
            2'd2:    shift_d[23:16] = bus.ld_byte;
            default: begin
              // Fourth byte completes the word: write it on this same edge.
              mem_we_s = 1'b1;
              wptr_d   = wptr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
              cnt_d    = cnt_q - 8'd1;
              if (cnt_q == 8'd1) begin
                state_d  = S_RUN;
                loaded_d = 1'b1;
              end else begin
                state_d  = S_DATA;
              end
            end
          endcase
        end else begin
          state_d = S_DATA;
        end
      end

      S_RUN: begin
        if (bus.memwe) begin
          mem_we_s    = 1'b1;
          mem_waddr_s = bus.memaddr;
          mem_wdata_s = bus.memdin;
        end else begin
          mem_we_s    = 1'b0;
        end
`ifdef MEM_RELOAD_EN
        // Hot reload: a byte here is a fresh count; core goes back into reset.
        if (xfer_s) begin
          cnt_d   = bus.ld_byte;
          wptr_d  = {ADDR_W{1'b0}};
          bidx_d  = 2'd0;
          state_d = S_DATA;
        end else begin
          state_d = S_RUN;
        end
`else
        state_d = S_RUN;
`endif
      end

      default: begin
        state_d = S_LEN;
      end
    endcase

    // Outputs follow the state being entered so they are registered and
    // change on the same edge as the state.
`ifdef MEM_RELOAD_EN
    ld_ready_d  = 1'b1;
`else
    ld_ready_d  = (state_d != S_RUN);
`endif
    core_rstn_d = (state_d == S_RUN);
  end

  // FSM, loader datapath and registered control outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_LEN;
      wptr_q      <= {ADDR_W{1'b0}};
      bidx_q      <= 2'd0;
      cnt_q       <= 8'd0;
      shift_q     <= 24'd0;
      ld_ready_q  <= 1'b1;
      core_rstn_q <= 1'b0;
      loaded_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      wptr_q      <= wptr_d;
      bidx_q      <= bidx_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      ld_ready_q  <= ld_ready_d;
      core_rstn_q <= core_rstn_d;
      loaded_q    <= loaded_d;
    end
  end

  // RAM array write; contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[mem_waddr_s] <= mem_wdata_s;
    end
  end

  // Synchronous read in every state; same-address write returns old data
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      memdout_q <= {DATA_W{1'b0}};
    end else begin
      memdout_q <= mem_q[bus.memaddr];
    end
  end

  assign bus.memdout  = memdout_q;
  assign bus.ld_ready = ld_ready_q;
  assign core_rstn    = core_rstn_q;
  assign loaded       = loaded_q;

endmodule

// File: tb/tb_core_mem_loader.sv
// tb_core_mem_loader: scenario tasks for core_mem_loader; a RAM model supplies
// expected read data, pushed to a queue when the read is issued and popped
// when memdout is sampled. Build with +define+MEM_RELOAD_EN to cover hot reload.
module tb_core_mem_loader;

  localparam int AW = 8;

  logic clk = 1'b0;
  logic rstn;
  logic core_rstn;
  logic loaded;

  core_mem_loader_if #(.ADDR_W(AW), .DATA_W(32)) bus_if ();

  core_mem_loader #(.ADDR_W(AW), .DATA_W(32)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .bus       (bus_if),
    .core_rstn (core_rstn),
    .loaded    (loaded)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int loaded_pulses = 0;

  logic [31:0] ref_mem [256];
  logic [31:0] exp_q [$];

  // count loaded pulses, sampled mid-cycle
  always @(negedge clk) begin
    if (loaded === 1'b1) loaded_pulses++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus_if.ld_valid = 1'b1;
    bus_if.ld_byte  = b;
    tick();
    bus_if.ld_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
  endtask

  // issue a read, queue the model's value, return what the DUT produced
  task automatic read_addr(input logic [AW-1:0] a, output logic [31:0] got);
    bus_if.memaddr = a;
    exp_q.push_back(ref_mem[a]);
    tick();
    got = bus_if.memdout;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    #3;
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    bus_if.memwe = 1'b0; bus_if.memaddr = '0; bus_if.memdin = '0;
    bus_if.ld_valid = 1'b0; bus_if.ld_byte = '0;
    rstn = 1'b0;
    repeat (2) tick();
    rstn = 1'b1;
    n_cmp++; if (bus_if.memdout !== 32'h0) begin n_err++; $display("FAIL reset_memdout got=%h exp=%h", bus_if.memdout, 32'h0); end
    n_cmp++; if (bus_if.ld_ready !== 1'b1) begin n_err++; $display("FAIL reset_ld_ready got=%b exp=1", bus_if.ld_ready); end
    n_cmp++; if (core_rstn !== 1'b0) begin n_err++; $display("FAIL reset_core_rstn got=%b exp=0", core_rstn); end
    n_cmp++; if (loaded !== 1'b0) begin n_err++; $display("FAIL reset_loaded got=%b exp=0", loaded); end
  endtask

  task automatic test_single_word();
    int p0;
    logic [31:0] got, exp;
    p0 = loaded_pulses;
    send_byte(8'h01);
    n_cmp++; if (bus_if.ld_ready !== 1'b1) begin n_err++; $display("FAIL single_ready_after_len got=%b exp=1", bus_if.ld_ready); end
    send_byte(8'h13); send_byte(8'h05); send_byte(8'h10);
    n_cmp++; if (core_rstn !== 1'b0 || loaded !== 1'b0) begin n_err++; $display("FAIL single_before_last got=%b%b exp=00", core_rstn, loaded); end
    send_byte(8'h00);
    ref_mem[0] = 32'h00100513;
    n_cmp++; if (loaded !== 1'b1) begin n_err++; $display("FAIL single_loaded got=%b exp=1", loaded); end
    n_cmp++; if (core_rstn !== 1'b1) begin n_err++; $display("FAIL single_core_rstn got=%b exp=1", core_rstn); end
    n_cmp++; if (bus_if.ld_ready !== 1'b0) begin n_err++; $display("FAIL single_ld_ready got=%b exp=0", bus_if.ld_ready); end
    read_addr(8'h00, got);
    exp = exp_q.pop_front();
    n_cmp++; if (got !== exp) begin n_err++; $display("FAIL single_ram0 got=%h exp=%h", got, exp); end
    n_cmp++; if (loaded_pulses - p0 !== 1) begin n_err++; $display("FAIL single_pulses got=%0d exp=1", loaded_pulses - p0); end
  endtask

  task automatic test_two_words();
    logic [31:0] got, exp;
    do_reset();
    send_byte(8'h02);
    send_word(32'hA1B2C3D4); ref_mem[0] = 32'hA1B2C3D4;
    send_word(32'h0BADF00D); ref_mem[1] = 32'h0BADF00D;
    read_addr(8'h00, got);
    exp = exp_q.pop_front();
    n_cmp++; if (got !== exp) begin n_err++; $display("FAIL two_ram0 got=%h exp=%h", got, exp); end
    // present address 1; data must not appear before the next edge
    bus_if.memaddr = 8'h01;
    exp_q.push_back(ref_mem[1]);
    #2;
    n_cmp++; if (bus_if.memdout !== ref_mem[0]) begin n_err++; $display("FAIL two_latency_early got=%h exp=%h", bus_if.memdout, ref_mem[0]); end
    tick();
    exp = exp_q.pop_front();
    n_cmp++; if (bus_if.memdout !== exp) begin n_err++; $display("FAIL two_ram1 got=%h exp=%h", bus_if.memdout, exp); end
  endtask

  task automatic test_read_during_write();
    logic [31:0] got, exp;
    bus_if.memwe = 1'b1; bus_if.memaddr = 8'h10; bus_if.memdin = 32'h12345678;
    tick();
    ref_mem[16] = 32'h12345678;
    bus_if.memdin = 32'hDEADBEEF;
    exp_q.push_back(ref_mem[16]);
    tick();
    bus_if.memwe = 1'b0;
    ref_mem[16] = 32'hDEADBEEF;
    exp = exp_q.pop_front();
    n_cmp++; if (bus_if.memdout !== exp) begin n_err++; $display("FAIL rdw_old got=%h exp=%h", bus_if.memdout, exp); end
    read_addr(8'h10, got);
    exp = exp_q.pop_front();
    n_cmp++; if (got !== exp) begin n_err++; $display("FAIL rdw_new got=%h exp=%h", got, exp); end
  endtask

  task automatic test_full_256();
    int early, p0;
    logic [31:0] w, got, exp;
    do_reset();
    p0 = loaded_pulses;
    early = 0;
    bus_if.memaddr = 8'h00;
    send_byte(8'h00);
    for (int i = 0; i < 256; i++) begin
      w = {i[7:0], ~i[7:0], 8'h3C, i[7:0] ^ 8'hA5};
      ref_mem[i] = w;
      for (int k = 0; k < 4; k++) begin
        send_byte(w[8*k +: 8]);
        if (!(i == 255 && k == 3) && (loaded === 1'b1 || core_rstn === 1'b1)) early++;
      end
    end
    n_cmp++; if (early !== 0) begin n_err++; $display("FAIL full_early_done got=%0d exp=0", early); end
    n_cmp++; if (loaded !== 1'b1 || core_rstn !== 1'b1) begin n_err++; $display("FAIL full_done got=%b%b exp=11", loaded, core_rstn); end
    tick();
    n_cmp++; if (loaded_pulses - p0 !== 1) begin n_err++; $display("FAIL full_pulses got=%0d exp=1", loaded_pulses - p0); end
    foreach (exp_q[j]) exp_q.delete(j);
    for (int a = 0; a < 256; a += 85) begin
      read_addr(a[7:0], got);
      exp = exp_q.pop_front();
      n_cmp++; if (got !== exp) begin n_err++; $display("FAIL full_ram addr=%0d got=%h exp=%h", a, got, exp); end
    end
  endtask

  task automatic test_midload_reset();
    logic [31:0] got, exp;
    int p0;
    do_reset();
    send_byte(8'h01);
    send_byte(8'hEE); send_byte(8'hFF);
    do_reset();
    p0 = loaded_pulses;
    n_cmp++; if (bus_if.ld_ready !== 1'b1 || core_rstn !== 1'b0) begin n_err++; $display("FAIL midrst_state got=%b%b exp=10", bus_if.ld_ready, core_rstn); end
    read_addr(8'h00, got);
    exp = exp_q.pop_front();
    n_cmp++; if (got !== exp) begin n_err++; $display("FAIL midrst_ram0_kept got=%h exp=%h", got, exp); end
    send_byte(8'h01);
    send_word(32'hCAFEF00D); ref_mem[0] = 32'hCAFEF00D;
    n_cmp++; if (core_rstn !== 1'b1 || loaded !== 1'b1) begin n_err++; $display("FAIL midrst_reload_done got=%b%b exp=11", core_rstn, loaded); end
    read_addr(8'h00, got);
    exp = exp_q.pop_front();
    n_cmp++; if (got !== exp) begin n_err++; $display("FAIL midrst_ram0_new got=%h exp=%h", got, exp); end
    n_cmp++; if (loaded_pulses - p0 !== 1) begin n_err++; $display("FAIL midrst_pulses got=%0d exp=1", loaded_pulses - p0); end
  endtask

  task automatic test_hot_reload();
    logic [31:0] got, exp;
    int p0;
    p0 = loaded_pulses;
`ifdef MEM_RELOAD_EN
    n_cmp++; if (bus_if.ld_ready !== 1'b1) begin n_err++; $display("FAIL reload_ready got=%b exp=1", bus_if.ld_ready); end
    send_byte(8'h01);
    n_cmp++; if (core_rstn !== 1'b0) begin n_err++; $display("FAIL reload_rst_low got=%b exp=0", core_rstn); end
    send_word(32'h11223344); ref_mem[0] = 32'h11223344;
    n_cmp++; if (core_rstn !== 1'b1) begin n_err++; $display("FAIL reload_rst_high got=%b exp=1", core_rstn); end
    tick();
    n_cmp++; if (loaded_pulses - p0 !== 1) begin n_err++; $display("FAIL reload_pulses got=%0d exp=1", loaded_pulses - p0); end
`else
    n_cmp++; if (bus_if.ld_ready !== 1'b0) begin n_err++; $display("FAIL noreload_ready got=%b exp=0", bus_if.ld_ready); end
    send_byte(8'h01);
    send_word(32'h11223344);
    n_cmp++; if (core_rstn !== 1'b1) begin n_err++; $display("FAIL noreload_core_rstn got=%b exp=1", core_rstn); end
    tick();
    n_cmp++; if (loaded_pulses - p0 !== 0) begin n_err++; $display("FAIL noreload_pulses got=%0d exp=0", loaded_pulses - p0); end
`endif
    read_addr(8'h00, got);
    exp = exp_q.pop_front();
    n_cmp++; if (got !== exp) begin n_err++; $display("FAIL hot_reload_ram0 got=%h exp=%h", got, exp); end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_two_words();
    test_read_during_write();
    test_full_256();
    test_midload_reset();
    test_hot_reload();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
